// File: rtl/toggle_pkg.sv
// toggle_pkg
//   Shared constants for the toggle event decoder.
//   CNT_W_DEFAULT : default width of the pending-event counter
//   CNT_MAX       : saturation value of that counter at the default width
package toggle_pkg;

    localparam int unsigned CNT_W_DEFAULT = 4;
    localparam int unsigned CNT_MAX       = (1 << CNT_W_DEFAULT) - 1;

endpackage : toggle_pkg

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level.
//   clk : sampling clock
//   rst : asynchronous active-high reset, clears both flops to 0
//   d_i : asynchronous input level
//   q_o : synchronized level (second flop)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule : sync_2ff

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder
//   Turns level changes of a remote toggle flip-flop into counted events.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   tog_in    : toggle level, asynchronous to clk; every change is one event
//   evt_ready : consumer takes one pending event this cycle
//   clr_ovf   : synchronous clear of the sticky overflow flag
//   evt_valid : at least one event pending
//   evt_pulse : one-cycle strobe per decoded event
//   pending   : number of undelivered events (saturating)
//   ovf       : sticky, an event was dropped at saturation
//   tog_level : synchronized and delayed copy of tog_in
module toggle_event_decoder
    import toggle_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic             evt_pulse,
    output logic [CNT_W-1:0] pending,
    output logic             ovf,
    output logic             tog_level
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    logic             s2;
    logic             s3_q;
    logic             pulse_q;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] pend_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             tog_edge;
    logic             pop;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (tog_in),
        .q_o (s2)
    );

    // Rising and falling changes of the toggle are the same kind of event.
    assign tog_edge  = s2 ^ s3_q;
    assign evt_valid = (pend_q != '0);
    // Gating with evt_valid keeps the counter from wrapping below zero.
    assign pop       = evt_valid & evt_ready;

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q & ~clr_ovf;
        unique case ({tog_edge, pop})
            2'b10: begin
                if (pend_q == PEND_MAX) begin
                    // Lost event; set wins over a simultaneous clear.
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + PEND_ONE;
                end
            end
            2'b01:   pend_d = pend_q - PEND_ONE;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            s3_q    <= s2;
            pulse_q <= tog_edge;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_pulse = pulse_q;
    assign pending   = pend_q;
    assign ovf       = ovf_q;
    assign tog_level = s3_q;

endmodule : toggle_event_decoder

// File: tb/tb_toggle_event_decoder.sv
module tb_toggle_event_decoder;

    localparam int CW  = 4;
    localparam int MAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tog_in = 1'b0;
    logic          evt_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          evt_valid;
    logic          evt_pulse;
    logic [CW-1:0] pending;
    logic          ovf;
    logic          tog_level;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: tog_in values sampled at the last four edges,
    // an event count and an overflow flag.
    bit samp [4];
    int exp_pend;
    bit exp_ovf;
    bit exp_pulse;
    bit exp_level;

    always #5 clk = ~clk;

    toggle_event_decoder #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (tog_in),
        .evt_ready (evt_ready),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .evt_pulse (evt_pulse),
        .pending   (pending),
        .ovf       (ovf),
        .tog_level (tog_level)
    );

    task automatic model_clear();
        for (int i = 0; i < 4; i++) samp[i] = 1'b0;
        exp_pend  = 0;
        exp_ovf   = 1'b0;
        exp_pulse = 1'b0;
        exp_level = 1'b0;
    endtask

    // Drive one cycle of inputs, advance one clock edge, update the model,
    // and return 1 ns after the edge with outputs settled.
    task automatic step(input bit t, input bit r, input bit c);
        bit pop;
        bit ev;
        tog_in    = t;
        evt_ready = r;
        clr_ovf   = c;
        @(posedge clk);
        pop = (exp_pend > 0) && r;
        samp[3] = samp[2];
        samp[2] = samp[1];
        samp[1] = samp[0];
        samp[0] = t;
        // A change seen at an edge surfaces two edges later.
        ev        = (samp[2] != samp[3]);
        exp_pulse = ev;
        exp_level = samp[2];
        if (c) exp_ovf = 1'b0;
        if (ev && !pop) begin
            if (exp_pend == MAX) exp_ovf = 1'b1;
            else exp_pend = exp_pend + 1;
        end else if (pop && !ev) begin
            exp_pend = exp_pend - 1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tog_in = 1'b0;
        evt_ready = 1'b0;
        clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({evt_valid, evt_pulse, pending, ovf, tog_level} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: got %b required 00000000",
                     {evt_valid, evt_pulse, pending, ovf, tog_level});
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int cyc = 1; cyc <= 9; cyc++) begin
            step(cyc >= 5, cyc == 8, 1'b0);
            tests_run++;
            if (evt_pulse !== exp_pulse || evt_pulse !== (cyc == 7)) begin
                tests_failed++;
                $display("FAIL single_pulse cyc %0d: got %b required %b", cyc, evt_pulse, exp_pulse);
            end
            tests_run++;
            if (pending !== CW'(exp_pend) || evt_valid !== (exp_pend != 0)) begin
                tests_failed++;
                $display("FAIL single_pending cyc %0d: got %0d/%b required %0d", cyc, pending, evt_valid, exp_pend);
            end
        end
        tests_run++;
        if (pending !== 0 || tog_level !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_final: got pending %0d level %b required 0 1", pending, tog_level);
        end
    endtask

    task automatic test_burst();
        int pulses = 0;
        bit t = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            t = ~t;
            for (int j = 0; j < 2; j++) begin
                step(t, 1'b0, 1'b0);
                pulses += evt_pulse;
            end
        end
        repeat (4) begin
            step(t, 1'b0, 1'b0);
            pulses += evt_pulse;
        end
        tests_run++;
        if (pulses != 3 || pending !== 3) begin
            tests_failed++;
            $display("FAIL burst_count: got pulses %0d pending %0d required 3 3", pulses, pending);
        end
        for (int k = 2; k >= 0; k--) begin
            step(t, 1'b1, 1'b0);
            tests_run++;
            if (pending !== CW'(k) || evt_valid !== (k != 0) || pending !== CW'(exp_pend)) begin
                tests_failed++;
                $display("FAIL burst_drain: got %0d/%b required %0d", pending, evt_valid, k);
            end
        end
    endtask

    task automatic test_simul();
        bit t = 1'b0;
        do_reset();
        repeat (2) begin
            t = ~t;
            repeat (2) step(t, 1'b0, 1'b0);
        end
        repeat (3) step(t, 1'b0, 1'b0);
        tests_run++;
        if (pending !== 2) begin
            tests_failed++;
            $display("FAIL simul_setup: got %0d required 2", pending);
        end
        t = ~t;
        step(t, 1'b0, 1'b0);
        step(t, 1'b0, 1'b0);
        // The event is on the edge detector now; pop on the same edge.
        step(t, 1'b1, 1'b0);
        tests_run++;
        if (evt_pulse !== 1'b1 || pending !== 2 || exp_pend != 2) begin
            tests_failed++;
            $display("FAIL simul_edge_pop: got pulse %b pending %0d required 1 2", evt_pulse, pending);
        end
    endtask

    task automatic test_saturate();
        bit t = 1'b0;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            t = ~t;
            repeat (2) begin
                step(t, 1'b0, 1'b0);
                tests_run++;
                if (pending !== CW'(exp_pend) || ovf !== exp_ovf || evt_pulse !== exp_pulse) begin
                    tests_failed++;
                    $display("FAIL sat_track chg %0d: got %0d/%b/%b required %0d/%b/%b",
                             k, pending, ovf, evt_pulse, exp_pend, exp_ovf, exp_pulse);
                end
            end
        end
        repeat (3) step(t, 1'b0, 1'b0);
        tests_run++;
        if (pending !== 15 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_full: got %0d/%b required 15/1", pending, ovf);
        end
        step(t, 1'b0, 1'b1);
        tests_run++;
        if (pending !== 15 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_clear: got %0d/%b required 15/0", pending, ovf);
        end
        // Clear held across a new overflow: the set must win on that edge.
        t = ~t;
        step(t, 1'b0, 1'b1);
        step(t, 1'b0, 1'b1);
        step(t, 1'b0, 1'b1);
        tests_run++;
        if (evt_pulse !== 1'b1 || ovf !== 1'b1 || exp_ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_set_wins: got pulse %b ovf %b required 1 1", evt_pulse, ovf);
        end
        step(t, 1'b0, 1'b1);
        tests_run++;
        if (ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_reclear: got %b required 0", ovf);
        end
    endtask

    task automatic test_mid_reset();
        bit t = 1'b0;
        int pulses = 0;
        do_reset();
        repeat (5) begin
            t = ~t;
            repeat (2) step(t, 1'b0, 1'b0);
        end
        repeat (3) step(t, 1'b0, 1'b0);
        t = ~t;
        step(t, 1'b0, 1'b0);
        step(t, 1'b0, 1'b0);
        tests_run++;
        if (pending !== 5) begin
            tests_failed++;
            $display("FAIL midrst_setup: got %0d required 5", pending);
        end
        #2;
        rst = 1'b1;
        tog_in = 1'b0;
        #1;
        tests_run++;
        if (pending !== 0 || ovf !== 1'b0 || evt_pulse !== 1'b0 || evt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_async: got %0d/%b/%b required 0/0/0", pending, ovf, evt_pulse);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        repeat (6) begin
            step(1'b0, 1'b1, 1'b0);
            pulses += evt_pulse;
        end
        tests_run++;
        if (pulses != 0 || pending !== 0 || tog_level !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_release: got pulses %0d pending %0d required 0 0", pulses, pending);
        end
    endtask

    task automatic test_random();
        bit t = 1'b0;
        int held = 2;
        int bad = 0;
        bit r;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (held >= 2 && $urandom_range(0, 2) != 0) begin
                t = ~t;
                held = 0;
            end
            held++;
            r = (cyc < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            step(t, r, $urandom_range(0, 24) == 0);
            tests_run++;
            if ({evt_pulse, pending, ovf, evt_valid, tog_level} !==
                {exp_pulse, CW'(exp_pend), exp_ovf, (exp_pend != 0), exp_level}) begin
                tests_failed++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random cyc %0d: got p%b n%0d o%b v%b l%b required p%b n%0d o%b l%b",
                             cyc, evt_pulse, pending, ovf, evt_valid, tog_level,
                             exp_pulse, exp_pend, exp_ovf, exp_level);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_burst();
        test_simul();
        test_saturate();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_toggle_event_decoder
